// File: rtl/fpu_arbiter_if.sv
// Client and fpu-side signal bundle for fpu_arbiter.
//   master : the arbiter's view (drives req_ack, resp_*, busy, grant_idx, fpu_* outputs)
//   slave  : the environment's view (clients plus the shared fpu)
// Client i owns slice [i*BITNESS +: BITNESS] of req_data_a/b and [i*4 +: 4] of req_op.
interface fpu_arbiter_if #(
  parameter int BITNESS    = 32,
  parameter int REQUESTERS = 4
);
  localparam int IDX_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  logic [REQUESTERS-1:0]         req_valid;
  logic [REQUESTERS-1:0]         req_ack;
  logic [REQUESTERS*BITNESS-1:0] req_data_a;
  logic [REQUESTERS*BITNESS-1:0] req_data_b;
  logic [REQUESTERS*4-1:0]       req_op;
  logic [REQUESTERS-1:0]         resp_valid;
  logic [REQUESTERS-1:0]         resp_ack;
  logic [BITNESS-1:0]            resp_data;
  logic                          resp_err;
  logic                          busy;
  logic [IDX_W-1:0]              grant_idx;
  logic                          fpu_input_rdy;
  logic                          fpu_input_ack;
  logic [BITNESS-1:0]            fpu_data_a;
  logic [BITNESS-1:0]            fpu_data_b;
  logic [3:0]                    fpu_operation;
  logic                          fpu_output_rdy;
  logic                          fpu_output_ack;
  logic [BITNESS-1:0]            fpu_result;

  modport master (
    input  req_valid, req_data_a, req_data_b, req_op, resp_ack,
           fpu_input_ack, fpu_output_rdy, fpu_result,
    output req_ack, resp_valid, resp_data, resp_err, busy, grant_idx,
           fpu_input_rdy, fpu_data_a, fpu_data_b, fpu_operation, fpu_output_ack
  );

  modport slave (
    output req_valid, req_data_a, req_data_b, req_op, resp_ack,
           fpu_input_ack, fpu_output_rdy, fpu_result,
    input  req_ack, resp_valid, resp_data, resp_err, busy, grant_idx,
           fpu_input_rdy, fpu_data_a, fpu_data_b, fpu_operation, fpu_output_ack
  );
endinterface

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one non-pipelined fpu among REQUESTERS clients.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : fpu_arbiter_if.master (client request/response and fpu handshakes)
// One operation is in flight at a time. A watchdog (TIMEOUT cycles in ISSUE or
// WAIT, 0 disables) forces an error response; a result still owed by the fpu
// after a WAIT timeout is marked stale, drained and discarded before the next
// grant. All outputs are registered.
module fpu_arbiter #(
  parameter int BITNESS    = 32,
  parameter int REQUESTERS = 4,
  parameter int TIMEOUT    = 256
) (
  input logic          clock,
  input logic          reset,
  fpu_arbiter_if.master bus
);
  localparam int IDX_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]      WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [REQUESTERS-1:0] ONE     = REQUESTERS'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DELIVER} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      rr_q, rr_d;
  logic                  stale_q, stale_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [REQUESTERS-1:0] req_ack_q, req_ack_d;
  logic [REQUESTERS-1:0] resp_valid_q, resp_valid_d;
  logic [BITNESS-1:0]    resp_data_q, resp_data_d;
  logic                  resp_err_q, resp_err_d;
  logic                  busy_q, busy_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic                  in_rdy_q, in_rdy_d;
  logic                  out_ack_q, out_ack_d;
  logic [BITNESS-1:0]    data_a_q, data_a_d;
  logic [BITNESS-1:0]    data_b_q, data_b_d;
  logic [3:0]            op_q, op_d;

  logic                  found;
  logic [IDX_W-1:0]      win;
  logic [IDX_W:0]        cand;
  logic [BITNESS-1:0]    sel_a, sel_b;
  logic [3:0]            sel_op;
  logic                  wd_hit;

  assign wd_hit = (TIMEOUT != 0) && (cnt_q == WD_LAST);

  // Round-robin search starting at rr_q, then operand mux for the winner.
  always_comb begin
    found  = 1'b0;
    win    = '0;
    cand   = '0;
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int unsigned i = 0; i < REQUESTERS; i++) begin
      cand = {1'b0, rr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(REQUESTERS)) cand = cand - (IDX_W+1)'(REQUESTERS);
      if (!found && bus.req_valid[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = cand[IDX_W-1:0];
      end
    end
    for (int unsigned i = 0; i < REQUESTERS; i++) begin
      if (win == IDX_W'(i)) begin
        sel_a  = bus.req_data_a[i*BITNESS +: BITNESS];
        sel_b  = bus.req_data_b[i*BITNESS +: BITNESS];
        sel_op = bus.req_op[i*4 +: 4];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    stale_d      = stale_q;
    cnt_d        = cnt_q;
    req_ack_d    = '0;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    grant_d      = grant_q;
    in_rdy_d     = in_rdy_q;
    out_ack_d    = 1'b0;
    data_a_d     = data_a_q;
    data_b_d     = data_b_q;
    op_d         = op_q;

    // Stale drain: ack the late result once, clear stale after the ack cycle.
    if (stale_q && state_q != S_WAIT) begin
      if (out_ack_q)               stale_d   = 1'b0;
      else if (bus.fpu_output_rdy) out_ack_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (!stale_q && found) begin
          grant_d   = win;
          data_a_d  = sel_a;
          data_b_d  = sel_b;
          op_d      = sel_op;
          req_ack_d = ONE << win;
          in_rdy_d  = 1'b1;
          cnt_d     = '0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.fpu_input_ack) begin
          in_rdy_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_WAIT;
        end else if (wd_hit) begin
          resp_data_d  = '1;
          resp_err_d   = 1'b1;
          in_rdy_d     = 1'b0;
          resp_valid_d = ONE << grant_q;
          state_d      = S_DELIVER;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        // A result on the timeout edge takes precedence over the watchdog.
        if (bus.fpu_output_rdy) begin
          resp_data_d  = bus.fpu_result;
          resp_err_d   = 1'b0;
          out_ack_d    = 1'b1;
          resp_valid_d = ONE << grant_q;
          state_d      = S_DELIVER;
        end else if (wd_hit) begin
          resp_data_d  = '1;
          resp_err_d   = 1'b1;
          stale_d      = 1'b1;
          resp_valid_d = ONE << grant_q;
          state_d      = S_DELIVER;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DELIVER: begin
        if (bus.resp_ack[grant_q]) begin
          resp_valid_d = '0;
          rr_d         = (grant_q == IDX_W'(REQUESTERS - 1)) ? '0 : grant_q + 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      rr_q         <= '0;
      stale_q      <= 1'b0;
      cnt_q        <= '0;
      req_ack_q    <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      grant_q      <= '0;
      in_rdy_q     <= 1'b0;
      out_ack_q    <= 1'b0;
      data_a_q     <= '0;
      data_b_q     <= '0;
      op_q         <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      stale_q      <= stale_d;
      cnt_q        <= cnt_d;
      req_ack_q    <= req_ack_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      busy_q       <= busy_d;
      grant_q      <= grant_d;
      in_rdy_q     <= in_rdy_d;
      out_ack_q    <= out_ack_d;
      data_a_q     <= data_a_d;
      data_b_q     <= data_b_d;
      op_q         <= op_d;
    end
  end

  assign bus.req_ack        = req_ack_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_data      = resp_data_q;
  assign bus.resp_err       = resp_err_q;
  assign bus.busy           = busy_q;
  assign bus.grant_idx      = grant_q;
  assign bus.fpu_input_rdy  = in_rdy_q;
  assign bus.fpu_output_ack = out_ack_q;
  assign bus.fpu_data_a     = data_a_q;
  assign bus.fpu_data_b     = data_b_q;
  assign bus.fpu_operation  = op_q;
endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter with a behavioural fpu stub
// (programmable input-ack and result latency, result = data_a ^ data_b).
module tb_fpu_arbiter;
  localparam int BW = 32;
  localparam int NR = 4;
  localparam int TO = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  fpu_arbiter_if #(.BITNESS(BW), .REQUESTERS(NR)) bus ();
  fpu_arbiter #(.BITNESS(BW), .REQUESTERS(NR), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  // fpu stub
  int ack_lat = 0;
  int res_lat = 1;
  int rdy_cnt, lcnt;
  logic pend, out_rdy;
  logic [BW-1:0] res;
  assign bus.fpu_input_ack  = bus.fpu_input_rdy && (rdy_cnt >= ack_lat);
  assign bus.fpu_output_rdy = out_rdy;
  assign bus.fpu_result     = res;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdy_cnt <= 0; lcnt <= 0; pend <= 1'b0; out_rdy <= 1'b0; res <= '0;
    end else begin
      rdy_cnt <= bus.fpu_input_rdy ? rdy_cnt + 1 : 0;
      if (bus.fpu_input_rdy && bus.fpu_input_ack) begin
        pend <= 1'b1; lcnt <= res_lat; res <= bus.fpu_data_a ^ bus.fpu_data_b;
      end else if (pend) begin
        if (lcnt <= 1) begin pend <= 1'b0; out_rdy <= 1'b1; end
        else lcnt <= lcnt - 1;
      end
      if (out_rdy && bus.fpu_output_ack) out_rdy <= 1'b0;
    end
  end

  task automatic set_req(input int i, input logic [BW-1:0] a, input logic [BW-1:0] b, input logic [3:0] op);
    bus.req_data_a[i*BW +: BW] = a;
    bus.req_data_b[i*BW +: BW] = b;
    bus.req_op[i*4 +: 4]       = op;
    bus.req_valid[i]           = 1'b1;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bus.req_ack, bus.resp_valid, bus.resp_data, bus.resp_err, bus.busy, bus.grant_idx,
         bus.fpu_input_rdy, bus.fpu_output_ack, bus.fpu_data_a, bus.fpu_data_b, bus.fpu_operation} !== '0) begin
      errors++; $display("FAIL reset_outputs: busy=%b req_ack=%b resp_valid=%b expected all zero", bus.busy, bus.req_ack, bus.resp_valid);
    end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_rotation();
    logic [BW-1:0] a [NR];
    logic [BW-1:0] b [NR];
    int n, g;
    for (int i = 0; i < NR; i++) begin
      a[i] = 32'h0000_0100 << i;
      b[i] = 32'h0000_0005 + i;
      set_req(i, a[i], b[i], 4'(i));
    end
    for (int t = 0; t < 5; t++) begin
      g = t % NR;
      n = 0;
      while (bus.req_ack == '0 && n < 40) begin @(negedge clock); n++; end
      checks++;
      if (bus.req_ack !== (4'b0001 << g)) begin
        errors++; $display("FAIL rotation_grant%0d: req_ack=%b expected %b", t, bus.req_ack, 4'b0001 << g);
      end
      if (t == 4) bus.req_valid = '0;
      n = 0;
      while (bus.resp_valid == '0 && n < 40) begin @(negedge clock); n++; end
      checks++;
      if (bus.resp_valid !== (4'b0001 << g) || bus.resp_data !== (a[g] ^ b[g]) || bus.resp_err !== 1'b0) begin
        errors++; $display("FAIL rotation_resp%0d: valid=%b data=%h err=%b expected %b %h 0",
                           t, bus.resp_valid, bus.resp_data, bus.resp_err, 4'b0001 << g, a[g] ^ b[g]);
      end
      bus.resp_ack = bus.resp_valid;
      @(negedge clock);
      bus.resp_ack = '0;
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_single();
    int n;
    ack_lat = 0; res_lat = 3;
    set_req(2, 32'h3F80_0000, 32'h4000_0000, 4'd0);
    n = 0;
    while (bus.req_ack == '0 && n < 20) begin @(negedge clock); n++; end
    checks++;
    if (bus.req_ack !== 4'b0100 || bus.fpu_operation !== 4'd0 || bus.grant_idx !== 2'd2 ||
        bus.busy !== 1'b1 || bus.fpu_input_rdy !== 1'b1 || bus.fpu_data_a !== 32'h3F80_0000) begin
      errors++; $display("FAIL single_grant: req_ack=%b op=%h grant=%0d busy=%b in_rdy=%b a=%h expected 0100 0 2 1 1 3f800000",
                         bus.req_ack, bus.fpu_operation, bus.grant_idx, bus.busy, bus.fpu_input_rdy, bus.fpu_data_a);
    end
    bus.req_valid = '0;
    @(negedge clock);
    checks++;
    if (bus.req_ack !== 4'b0000) begin
      errors++; $display("FAIL single_ack_pulse: req_ack=%b expected 0000", bus.req_ack);
    end
    n = 0;
    while (bus.resp_valid == '0 && n < 30) begin @(negedge clock); n++; end
    checks++;
    if (bus.resp_valid !== 4'b0100 || bus.resp_data !== 32'h7F80_0000 || bus.resp_err !== 1'b0) begin
      errors++; $display("FAIL single_resp: valid=%b data=%h err=%b expected 0100 7f800000 0", bus.resp_valid, bus.resp_data, bus.resp_err);
    end
    bus.resp_ack = 4'b0100;
    @(negedge clock);
    bus.resp_ack = '0;
    checks++;
    if (bus.busy !== 1'b0 || bus.resp_valid !== 4'b0000) begin
      errors++; $display("FAIL single_done: busy=%b valid=%b expected 0 0000", bus.busy, bus.resp_valid);
    end
  endtask

  task automatic test_timeout_issue();
    int n;
    ack_lat = 1000;
    set_req(0, 32'h1234_5678, 32'h0F0F_0F0F, 4'd1);
    n = 0;
    while (bus.req_ack == '0 && n < 20) begin @(negedge clock); n++; end
    bus.req_valid = '0;
    n = 0;
    while (bus.resp_valid == '0 && n < 30) begin @(negedge clock); n++; end
    checks++;
    if (n !== TO) begin
      errors++; $display("FAIL issue_timeout_cycles: got %0d expected %0d", n, TO);
    end
    checks++;
    if (bus.resp_valid !== 4'b0001 || bus.resp_data !== 32'hFFFF_FFFF || bus.resp_err !== 1'b1 || bus.fpu_input_rdy !== 1'b0) begin
      errors++; $display("FAIL issue_timeout_resp: valid=%b data=%h err=%b in_rdy=%b expected 0001 ffffffff 1 0",
                         bus.resp_valid, bus.resp_data, bus.resp_err, bus.fpu_input_rdy);
    end
    checks++;
    if (dut.stale_q !== 1'b0) begin
      errors++; $display("FAIL issue_timeout_stale: stale=%b expected 0", dut.stale_q);
    end
    bus.resp_ack = 4'b0001;
    @(negedge clock);
    bus.resp_ack = '0;
    ack_lat = 0;
    @(negedge clock);
  endtask

  task automatic test_late_output();
    int n, early;
    ack_lat = 0; res_lat = 20;
    set_req(3, 32'hAAAA_0000, 32'h0000_5555, 4'd2);
    n = 0;
    while (bus.req_ack == '0 && n < 20) begin @(negedge clock); n++; end
    checks++;
    if (bus.req_ack !== 4'b1000) begin
      errors++; $display("FAIL late_grant: req_ack=%b expected 1000", bus.req_ack);
    end
    bus.req_valid = '0;
    set_req(1, 32'h0000_00F0, 32'h0000_000F, 4'd3);
    early = 0;
    n = 0;
    while (bus.resp_valid == '0 && n < 40) begin @(negedge clock); n++; if (bus.req_ack != '0) early++; end
    res_lat = 2;
    checks++;
    if (bus.resp_valid !== 4'b1000 || bus.resp_data !== 32'hFFFF_FFFF || bus.resp_err !== 1'b1 || dut.stale_q !== 1'b1) begin
      errors++; $display("FAIL late_timeout_resp: valid=%b data=%h err=%b stale=%b expected 1000 ffffffff 1 1",
                         bus.resp_valid, bus.resp_data, bus.resp_err, dut.stale_q);
    end
    bus.resp_ack = 4'b1000;
    @(negedge clock);
    bus.resp_ack = '0;
    n = 0;
    while (bus.fpu_output_ack !== 1'b1 && n < 40) begin
      if (bus.req_ack != '0) early++;
      @(negedge clock); n++;
    end
    checks++;
    if (bus.fpu_output_ack !== 1'b1 || early !== 0) begin
      errors++; $display("FAIL late_drain: out_ack=%b grants_before_drain=%0d expected 1 0", bus.fpu_output_ack, early);
    end
    @(negedge clock);
    checks++;
    if (bus.fpu_output_ack !== 1'b0 || bus.resp_valid !== 4'b0000) begin
      errors++; $display("FAIL late_drain_pulse: out_ack=%b valid=%b expected 0 0000", bus.fpu_output_ack, bus.resp_valid);
    end
    n = 0;
    while (bus.req_ack == '0 && n < 10) begin @(negedge clock); n++; end
    checks++;
    if (bus.req_ack !== 4'b0010) begin
      errors++; $display("FAIL late_next_grant: req_ack=%b expected 0010", bus.req_ack);
    end
    bus.req_valid = '0;
    n = 0;
    while (bus.resp_valid == '0 && n < 30) begin @(negedge clock); n++; end
    checks++;
    if (bus.resp_valid !== 4'b0010 || bus.resp_data !== 32'h0000_00FF || bus.resp_err !== 1'b0) begin
      errors++; $display("FAIL late_next_resp: valid=%b data=%h err=%b expected 0010 000000ff 0", bus.resp_valid, bus.resp_data, bus.resp_err);
    end
    bus.resp_ack = 4'b0010;
    @(negedge clock);
    bus.resp_ack = '0;
    @(negedge clock);
  endtask

  task automatic test_reset_mid_op();
    int n;
    ack_lat = 0; res_lat = 6;
    set_req(2, 32'hDEAD_BEEF, 32'h0BAD_F00D, 4'd1);
    n = 0;
    while (bus.req_ack == '0 && n < 20) begin @(negedge clock); n++; end
    bus.req_valid = '0;
    @(negedge clock);
    checks++;
    if (bus.busy !== 1'b1 || bus.grant_idx !== 2'd2) begin
      errors++; $display("FAIL midop_busy: busy=%b grant=%0d expected 1 2", bus.busy, bus.grant_idx);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bus.req_ack, bus.resp_valid, bus.resp_data, bus.resp_err, bus.busy, bus.grant_idx,
         bus.fpu_input_rdy, bus.fpu_output_ack, bus.fpu_data_a, bus.fpu_data_b, bus.fpu_operation} !== '0) begin
      errors++; $display("FAIL midop_reset_outputs: busy=%b grant=%0d a=%h expected all zero", bus.busy, bus.grant_idx, bus.fpu_data_a);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    res_lat = 2;
    set_req(1, 32'h0000_0011, 32'h0000_0022, 4'd0);
    set_req(3, 32'h0000_0033, 32'h0000_0044, 4'd0);
    n = 0;
    while (bus.req_ack == '0 && n < 20) begin @(negedge clock); n++; end
    checks++;
    if (bus.req_ack !== 4'b0010) begin
      errors++; $display("FAIL midop_regrant: req_ack=%b expected 0010", bus.req_ack);
    end
    bus.req_valid = '0;
    n = 0;
    while (bus.resp_valid == '0 && n < 30) begin @(negedge clock); n++; end
    bus.resp_ack = bus.resp_valid;
    @(negedge clock);
    bus.resp_ack = '0;
    @(negedge clock);
  endtask

  task automatic test_resp_holdoff();
    int n;
    ack_lat = 0; res_lat = 2;
    set_req(0, 32'hC0DE_0000, 32'h0000_CAFE, 4'd2);
    n = 0;
    while (bus.req_ack == '0 && n < 20) begin @(negedge clock); n++; end
    bus.req_valid = '0;
    set_req(2, 32'h0000_0001, 32'h0000_0002, 4'd0);
    n = 0;
    while (bus.resp_valid == '0 && n < 30) begin @(negedge clock); n++; end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (bus.resp_valid !== 4'b0001 || bus.resp_data !== 32'hC0DE_CAFE || bus.req_ack !== 4'b0000 || bus.busy !== 1'b1) begin
        errors++; $display("FAIL holdoff_cycle%0d: valid=%b data=%h req_ack=%b busy=%b expected 0001 c0decafe 0000 1",
                           c, bus.resp_valid, bus.resp_data, bus.req_ack, bus.busy);
      end
      bus.resp_ack = 4'b0010;  // other bits must be ignored
      @(negedge clock);
    end
    bus.resp_ack = 4'b0001;
    @(negedge clock);
    bus.resp_ack = '0;
    checks++;
    if (bus.busy !== 1'b0 || bus.resp_valid !== 4'b0000) begin
      errors++; $display("FAIL holdoff_release: busy=%b valid=%b expected 0 0000", bus.busy, bus.resp_valid);
    end
    n = 0;
    while (bus.req_ack == '0 && n < 10) begin @(negedge clock); n++; end
    checks++;
    if (bus.req_ack !== 4'b0100) begin
      errors++; $display("FAIL holdoff_next_grant: req_ack=%b expected 0100", bus.req_ack);
    end
    bus.req_valid = '0;
    n = 0;
    while (bus.resp_valid == '0 && n < 30) begin @(negedge clock); n++; end
    checks++;
    if (bus.resp_valid !== 4'b0100 || bus.resp_data !== 32'h0000_0003) begin
      errors++; $display("FAIL holdoff_next_resp: valid=%b data=%h expected 0100 00000003", bus.resp_valid, bus.resp_data);
    end
    bus.resp_ack = 4'b0100;
    @(negedge clock);
    bus.resp_ack = '0;
  endtask

  initial begin
    bus.req_valid  = '0;
    bus.req_data_a = '0;
    bus.req_data_b = '0;
    bus.req_op     = '0;
    bus.resp_ack   = '0;
    test_reset();
    test_rotation();
    test_single();
    test_timeout_issue();
    test_late_output();
    test_reset_mid_op();
    test_resp_holdoff();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fpu_arbiter.md
Name: fpu_arbiter

Overview:
- Shares one non-pipelined fpu instance among REQUESTERS clients.
- Round-robin grant; exactly one operation in flight.
- Drives the fpu operand/operation inputs and the input_rdy/input_ack and output_rdy/output_ack handshakes.
- Returns each result to the requester that issued it, with a watchdog so a hung fpu cannot lock the arbiter.

Parameters:
- BITNESS, 32, operand/result width; must match the fpu bitness.
- REQUESTERS, 4, number of clients (1..16); IDX_W = max(1, $clog2(REQUESTERS)).
- TIMEOUT, 256, max cycles allowed in ISSUE or WAIT; 0 disables the watchdog.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  REQUESTERS  per-client request, level; held until req_ack.
- req_ack  out  REQUESTERS  one-cycle acceptance pulse, one-hot.
- req_data_a  in  REQUESTERS*BITNESS  operand A; client i at slice [i*BITNESS +: BITNESS].
- req_data_b  in  REQUESTERS*BITNESS  operand B, same packing.
- req_op  in  REQUESTERS*4  Operation_t per client (add/sub/mul/div encodings).
- resp_valid  out  REQUESTERS  one-hot; held until resp_ack of the same bit.
- resp_ack  in  REQUESTERS  client consumes the response.
- resp_data  out  BITNESS  result for the client flagged in resp_valid.
- resp_err  out  1  response produced by the watchdog, not by the fpu.
- busy  out  1  high whenever state != IDLE.
- grant_idx  out  IDX_W  index of the current owner; valid while busy.
- fpu_input_rdy  out  1  to fpu input_rdy.
- fpu_input_ack  in  1  from fpu input_ack; treated as a level.
- fpu_data_a  out  BITNESS  to fpu data_a.
- fpu_data_b  out  BITNESS  to fpu data_b.
- fpu_operation  out  4  to fpu operation.
- fpu_output_rdy  in  1  from fpu output_rdy.
- fpu_output_ack  out  1  to fpu output_ack.
- fpu_result  in  BITNESS  from fpu result.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE, rr_ptr = 0, stale = 0, watchdog counter = 0.
  - All outputs 0, including req_ack, resp_valid, resp_data, resp_err, busy, grant_idx, fpu_input_rdy, fpu_output_ack, fpu_data_a, fpu_data_b and fpu_operation.
  - Reset mid-operation abandons the transaction with no response; the fpu is expected to be reset together with the arbiter.
- All outputs are registered.
- IDLE:
  - Search order is rr_ptr, rr_ptr+1, ... mod REQUESTERS; the first set req_valid bit wins.
  - On the sampling edge, latch the winner's operands and op into fpu_data_a, fpu_data_b and fpu_operation, and set grant_idx.
  - In the next cycle req_ack[g] = 1 for exactly one cycle, fpu_input_rdy = 1, and state = ISSUE.
  - No valid request: stay in IDLE.
- ISSUE:
  - fpu_input_rdy and operands held stable.
  - First cycle with fpu_input_ack = 1: drop fpu_input_rdy, clear the counter, go to WAIT.
- WAIT:
  - On fpu_output_rdy = 1: capture fpu_result into resp_data, resp_err = 0, pulse fpu_output_ack for one cycle, go to DELIVER.
- Watchdog (ISSUE and WAIT, TIMEOUT > 0):
  - The counter increments every cycle spent in ISSUE or WAIT.
  - Reaching TIMEOUT: resp_data = all ones, resp_err = 1, fpu_input_rdy = 0, go to DELIVER.
  - Timeout from WAIT sets stale = 1. Timeout from ISSUE does not set stale.
- DELIVER:
  - resp_valid[grant_idx] = 1 until resp_ack[grant_idx] = 1 is sampled.
  - On that edge: clear resp_valid, set rr_ptr = (grant_idx + 1) mod REQUESTERS, go to IDLE.
  - resp_ack on other bits is ignored.
- Stale drain:
  - While stale = 1, fpu_output_rdy seen in any state other than WAIT is acked for one cycle and discarded; then stale = 0.
  - Grant in IDLE is blocked while stale = 1.
- Requester rules:
  - A client may deassert req_valid only after req_ack.
  - A client re-asserting immediately is not re-granted before other pending clients, because rr_ptr rotates past it.
- Simultaneous events:
  - All clients requesting: grants go in strict rotation.
  - fpu_output_rdy arriving on the same edge the counter reaches TIMEOUT: the result wins, resp_err = 0.
- Latency with a 0-wait fpu: req_valid sampled at edge k gives req_ack in cycle k+1; resp_valid follows once the fpu result returns.

Test Plan:
- Bench uses a behavioural fpu stub with programmable ack and result latency; stub result = data_a XOR data_b.
- Single client: client 2 requests a=0x3F800000, b=0x40000000, op=add, with stub latency 3. Required: req_ack[2] pulses once; fpu_operation = 0; resp_valid[2] with resp_data = 0x7F800000 and resp_err = 0; busy drops the cycle after resp_ack.
- All four clients request continuously: grant order 0,1,2,3,0; no client is granted twice while another is pending.
- Stub never raises input_ack, TIMEOUT = 8: resp_valid[g] rises with resp_data = 0xFFFFFFFF and resp_err = 1; stale stays 0.
- Stub acks input but its output arrives 20 cycles later, TIMEOUT = 8: error response delivered; the late output_rdy is acked and discarded; the next grant waits until stale clears.
- Reset pulled low while in WAIT: all outputs are 0 immediately (asynchronously); the next request after release is granted starting from client 0.
- resp_ack held off for 10 cycles: resp_valid and resp_data stay stable throughout; no new grant occurs until resp_ack.
